// File: rtl/rob_ctrl.sv
// Reorder-buffer control: tracks allocation, out-of-order completion and
// in-order dual retirement of up to ROB_SIZE in-flight entries.
module rob_ctrl #(
    parameter int ROB_SIZE = 16,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    output logic             alloc_grant,
    output logic [IDX_W-1:0] alloc_idx,
    input  logic             comp_a_valid,
    input  logic [IDX_W-1:0] comp_a_idx,
    input  logic             comp_b_valid,
    input  logic [IDX_W-1:0] comp_b_idx,
    input  logic             flush,
    output logic             ret0_valid,
    output logic [IDX_W-1:0] ret0_idx,
    output logic             ret1_valid,
    output logic [IDX_W-1:0] ret1_idx,
    output logic [IDX_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [ROB_SIZE-1:0] valid_q, valid_d;
    logic [ROB_SIZE-1:0] comp_q, comp_d;
    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d, head_p1;
    logic [IDX_W:0]      count_q, count_d;

    assign head_p1   = head_q + IDX_W'(1);
    assign full      = (count_q == (IDX_W+1)'(ROB_SIZE));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign alloc_idx = tail_q;
    assign ret0_idx  = head_q;
    assign ret1_idx  = head_p1;

    // Grant looks only at current occupancy, so a same-cycle retire never frees a slot early.
    assign alloc_grant = rst_n && alloc_req && !full && !flush;
    assign ret0_valid  = !empty && !flush && valid_q[head_q] && comp_q[head_q];
    assign ret1_valid  = ret0_valid && valid_q[head_p1] && comp_q[head_p1];

    always_comb begin
        valid_d = valid_q;
        comp_d  = comp_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (IDX_W+1)'(alloc_grant)
                - (IDX_W+1)'(ret0_valid) - (IDX_W+1)'(ret1_valid);

        // A strobe to the tail being allocated finds valid==0 and is dropped naturally.
        if (comp_a_valid && valid_q[comp_a_idx]) comp_d[comp_a_idx] = 1'b1;
        if (comp_b_valid && valid_q[comp_b_idx]) comp_d[comp_b_idx] = 1'b1;

        if (ret0_valid) begin
            valid_d[head_q] = 1'b0;
            comp_d[head_q]  = 1'b0;
            head_d          = head_p1;
        end
        if (ret1_valid) begin
            valid_d[head_p1] = 1'b0;
            comp_d[head_p1]  = 1'b0;
            head_d           = head_q + IDX_W'(2);
        end

        if (alloc_grant) begin
            valid_d[tail_q] = 1'b1;
            comp_d[tail_q]  = 1'b0;
            tail_d          = tail_q + IDX_W'(1);
        end

        if (flush) begin
            valid_d = '0;
            comp_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            comp_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            comp_q  <= comp_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_rob_ctrl.sv
// Randomized scoreboard bench for rob_ctrl against a queue-based model of
// in-order allocation/retirement with out-of-order completion.
module tb_rob_ctrl;

    localparam int N = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_req, alloc_grant;
    logic [3:0] alloc_idx;
    logic       comp_a_valid, comp_b_valid, flush;
    logic [3:0] comp_a_idx, comp_b_idx;
    logic       ret0_valid, ret1_valid;
    logic [3:0] ret0_idx, ret1_idx;
    logic [4:0] count;
    logic       full, empty;

    rob_ctrl #(.ROB_SIZE(N), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_grant(alloc_grant), .alloc_idx(alloc_idx),
        .comp_a_valid(comp_a_valid), .comp_a_idx(comp_a_idx),
        .comp_b_valid(comp_b_valid), .comp_b_idx(comp_b_idx),
        .flush(flush),
        .ret0_valid(ret0_valid), .ret0_idx(ret0_idx),
        .ret1_valid(ret1_valid), .ret1_idx(ret1_idx),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit grant; int aidx; bit r0; bit r1; int r0i; int r1i; int cnt; bit full; bit empty;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Model: the ROB is simply an ordered queue of occupied indices plus a done flag per index.
    int   occ[$];
    bit   done[N];
    int   m_head = 0;
    int   m_tail = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("alloc_grant", 32'(alloc_grant), 32'(e.grant));
            checkOutput("alloc_idx",   32'(alloc_idx),   e.aidx);
            checkOutput("ret0_valid",  32'(ret0_valid),  32'(e.r0));
            checkOutput("ret1_valid",  32'(ret1_valid),  32'(e.r1));
            checkOutput("ret0_idx",    32'(ret0_idx),    e.r0i);
            checkOutput("ret1_idx",    32'(ret1_idx),    e.r1i);
            checkOutput("count",       32'(count),       e.cnt);
            checkOutput("full",        32'(full),        32'(e.full));
            checkOutput("empty",       32'(empty),       32'(e.empty));
        end
    end

    function automatic bit isOcc(input int idx);
        foreach (occ[k]) if (occ[k] == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void modelClear();
        occ.delete();
        m_head = 0;
        m_tail = 0;
        foreach (done[k]) done[k] = 1'b0;
    endfunction

    // One clock of stimulus: drive, predict this cycle's outputs, then advance the model at the edge.
    task automatic applyStimulus(input bit req, input bit fl, input bit av, input int ai,
                                 input bit bv, input int bi);
        exp_t e;
        int   n;
        #1;
        alloc_req    = req;
        flush        = fl;
        comp_a_valid = av;
        comp_a_idx   = ai[3:0];
        comp_b_valid = bv;
        comp_b_idx   = bi[3:0];
        n       = occ.size();
        e.full  = (n == N);
        e.empty = (n == 0);
        e.grant = req && !e.full && !fl;
        e.aidx  = m_tail;
        e.r0    = 1'b0;
        e.r1    = 1'b0;
        if (!fl && n >= 1) e.r0 = done[occ[0]];
        if (e.r0 && n >= 2) e.r1 = done[occ[1]];
        e.r0i   = m_head;
        e.r1i   = (m_head + 1) % N;
        e.cnt   = n;
        exp_q.push_back(e);
        @(posedge clk);
        if (fl) begin
            modelClear();
        end else begin
            if (av && isOcc(ai)) done[ai] = 1'b1;
            if (bv && isOcc(bi)) done[bi] = 1'b1;
            if (e.r0) begin void'(occ.pop_front()); m_head = (m_head + 1) % N; end
            if (e.r1) begin void'(occ.pop_front()); m_head = (m_head + 1) % N; end
            if (e.grant) begin
                occ.push_back(m_tail);
                done[m_tail] = 1'b0;
                m_tail = (m_tail + 1) % N;
            end
        end
    endtask

    function automatic exp_t resetExp();
        exp_t e;
        e.grant = 0; e.aidx = 0; e.r0 = 0; e.r1 = 0; e.r0i = 0; e.r1i = 1;
        e.cnt = 0; e.full = 0; e.empty = 1;
        return e;
    endfunction

    // Pulse rst_n low between edges with activity on the inputs; outputs must settle before the next edge.
    task automatic pulseReset();
        #3;
        rst_n        = 1'b0;
        alloc_req    = 1'b1;
        comp_a_valid = 1'b1;
        comp_a_idx   = 4'd0;
        #1;
        exp_q.push_back(resetExp());
        @(negedge clk);
        #1;
        modelClear();
        alloc_req    = 1'b0;
        comp_a_valid = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
    endtask

    function automatic int pickIdx();
        if (occ.size() > 0 && ($urandom % 4) != 0)
            return occ[$urandom_range(0, occ.size() - 1)];
        return int'($urandom % N);
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int allocPct, compPct;
        rst_n = 1'b0;
        alloc_req = 0; flush = 0; comp_a_valid = 0; comp_b_valid = 0;
        comp_a_idx = 0; comp_b_idx = 0;
        #1;
        exp_q.push_back(resetExp());
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);

        // Fill: 17 requests, the last one refused.
        for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        // Full with same-cycle retire, then a grant the cycle after.
        applyStimulus(1, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        // Flush together with alloc and completions.
        applyStimulus(1, 1, 1, 2, 1, 3);
        applyStimulus(0, 0, 0, 0, 0, 0);
        // Dual retire, then out-of-order completion.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 1, 0);
        applyStimulus(0, 0, 1, 3, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 2, 1, 2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        // Completion to the tail being allocated is dropped.
        applyStimulus(1, 0, 1, 4, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        pulseReset();
        applyStimulus(1, 0, 0, 0, 0, 0);

        allocPct = 60;
        compPct  = 50;
        for (int c = 0; c < 2000; c++) begin
            if (c % 100 == 0) begin
                allocPct = $urandom_range(20, 95);
                compPct  = $urandom_range(10, 90);
            end
            if (c % 700 == 350) begin
                pulseReset();
            end else begin
                applyStimulus(($urandom % 100) < allocPct,
                              ($urandom % 100) < 2,
                              ($urandom % 100) < compPct, pickIdx(),
                              ($urandom % 100) < compPct, pickIdx());
            end
        end

        #1;
        alloc_req = 0; flush = 0; comp_a_valid = 0; comp_b_valid = 0;
        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
